// File: rtl/decoder3_8_strobe.sv
// Sequential 3-to-8 decoder: an accepted code drives y[code] for HOLD cycles, then GAP idle cycles.
// Optional retrigger during HOLD is enabled by defining DEC3_8_RETRIG_EN.
module decoder3_8_strobe #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] a,
    output logic [7:0] y,
    output logic       busy,
    output logic       done,
    output logic [2:0] last_code
);

    generate
        if (HOLD < 1 || HOLD > 255 || GAP < 0 || GAP > 255) begin : g_bad_param
            $error("decoder3_8_strobe: HOLD must be 1..255 and GAP 0..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_CNT = 8'(HOLD - 1);
    localparam logic [7:0] GAP_CNT  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic       GAP_EN   = (GAP > 0) ? 1'b1 : 1'b0;

    function automatic logic [7:0] dec3(input logic [2:0] code);
        logic [7:0] one_hot;
        one_hot = 8'd1 << code;
        return one_hot;
    endfunction

    state_t     state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic [7:0] y_r, y_s;
    logic       done_r, done_s;
    logic       busy_r, busy_s;
    logic [2:0] last_code_r, last_code_s;
    logic       accept_s;

`ifdef DEC3_8_RETRIG_EN
    assign in_ready = en & ((state_r == ST_IDLE) | (state_r == ST_HOLD));
`else
    assign in_ready = en & (state_r == ST_IDLE);
`endif

    assign accept_s  = in_valid & in_ready;
    assign y         = y_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign last_code = last_code_r;

    // Next-state and next-output logic; abort beats accept, accept (retrigger) beats expiry.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        y_s         = y_r;
        done_s      = 1'b0;
        last_code_s = last_code_r;
        if (!en) begin
            state_s = ST_IDLE;
            cnt_s   = 8'd0;
            y_s     = 8'd0;
        end else if (accept_s) begin
            state_s     = ST_HOLD;
            cnt_s       = HOLD_CNT;
            y_s         = dec3(a);
            last_code_s = a;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_s = 8'd0;
                    y_s   = 8'd0;
                end
                ST_HOLD: begin
                    if (cnt_r != 8'd0) begin
                        cnt_s = cnt_r - 8'd1;
                    end else begin
                        y_s    = 8'd0;
                        done_s = 1'b1;
                        if (GAP_EN) begin
                            state_s = ST_GAP;
                            cnt_s   = GAP_CNT;
                        end else begin
                            state_s = ST_IDLE;
                            cnt_s   = 8'd0;
                        end
                    end
                end
                ST_GAP: begin
                    y_s = 8'd0;
                    if (cnt_r != 8'd0) begin
                        cnt_s = cnt_r - 8'd1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                    y_s     = 8'd0;
                end
            endcase
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            y_r         <= 8'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            last_code_r <= 3'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            y_r         <= y_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            last_code_r <= last_code_s;
        end
    end

endmodule

// File: tb/tb_decoder3_8_strobe.sv
// Table-driven scoreboard bench for decoder3_8_strobe (HOLD=4 with GAP=1, plus a GAP=0 instance).
module tb_decoder3_8_strobe;

`ifdef DEC3_8_RETRIG_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    typedef struct packed {
        bit         sel;
        bit         en;
        bit         v;
        logic [2:0] a;
        bit         rdy;
        logic [7:0] y;
        bit         done;
        bit         busy;
        logic [2:0] lc;
    } vec_t;

    typedef struct packed {
        logic [7:0] y;
        bit         done;
        bit         busy;
        logic [2:0] lc;
    } exp_t;

    logic       clk, rst_n;
    logic       en, in_valid, in_ready, busy, done;
    logic [2:0] a, last_code;
    logic [7:0] y;
    logic       g_en, g_valid, g_ready, g_busy, g_done;
    logic [2:0] g_a, g_last_code;
    logic [7:0] g_y;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];
    exp_t sbq[$];

    decoder3_8_strobe #(.HOLD(4), .GAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .y(y), .busy(busy), .done(done), .last_code(last_code)
    );

    decoder3_8_strobe #(.HOLD(4), .GAP(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .en(g_en), .in_valid(g_valid), .in_ready(g_ready),
        .a(g_a), .y(g_y), .busy(g_busy), .done(g_done), .last_code(g_last_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(bit s, bit e, bit v, logic [2:0] aa, bit r,
                                logic [7:0] yy, bit d, bit b, logic [2:0] lc);
        vec_t t;
        t = '{sel: s, en: e, v: v, a: aa, rdy: r, y: yy, done: d, busy: b, lc: lc};
        return t;
    endfunction

    function automatic void add(bit s, bit e, bit v, logic [2:0] aa, bit r,
                                logic [7:0] yy, bit d, bit b, logic [2:0] lc);
        vecs.push_back(mk(s, e, v, aa, r, yy, d, b, lc));
    endfunction

    // One cycle: drive inputs at negedge, check in_ready, push expectation, compare after posedge.
    task automatic step(input vec_t t);
        exp_t e;
        logic [7:0] ay;
        @(negedge clk);
        if (!t.sel) begin
            en = t.en; in_valid = t.v; a = t.a;
        end else begin
            g_en = t.en; g_valid = t.v; g_a = t.a;
        end
        #1;
        cmp("in_ready", t.sel ? g_ready : in_ready, {7'd0, t.rdy});
        sbq.push_back('{y: t.y, done: t.done, busy: t.busy, lc: t.lc});
        @(posedge clk);
        #1;
        e  = sbq.pop_front();
        ay = t.sel ? g_y : y;
        cmp("y", ay, e.y);
        cmp("done", t.sel ? g_done : done, {7'd0, e.done});
        cmp("busy", t.sel ? g_busy : busy, {7'd0, e.busy});
        cmp("last_code", t.sel ? g_last_code : last_code, {5'd0, e.lc});
        cmp("onehot", {7'd0, ($countones(ay) <= 1)}, 8'd1);
    endtask

    initial begin
        logic [7:0] one;
        logic [2:0] nx;
        one = 8'd1;

        // accept a=5: y=20 for 4 cycles, done, gap, then ready
        add(1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 8'h20, 1'b0, 1'b1, 3'd5);
        for (int j = 0; j < 3; j++) add(1'b0, 1'b1, 1'b0, 3'd0, RT, 8'h20, 1'b0, 1'b1, 3'd5);
        add(1'b0, 1'b1, 1'b0, 3'd0, RT, 8'h00, 1'b1, 1'b1, 3'd5);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd5);
        // sweep 0..7 with in_valid held for the next code
        for (int i = 0; i < 8; i++) begin
            nx = 3'(i + 1);
            add(1'b0, 1'b1, 1'b1, 3'(i), 1'b1, one << i, 1'b0, 1'b1, 3'(i));
            for (int j = 0; j < 3; j++)
                add(1'b0, 1'b1, ~RT, nx, RT, one << i, 1'b0, 1'b1, 3'(i));
            add(1'b0, 1'b1, ~RT, nx, RT, 8'h00, 1'b1, 1'b1, 3'(i));
            add(1'b0, 1'b1, (i < 7), nx, 1'b0, 8'h00, 1'b0, 1'b0, 3'(i));
        end
        // abort in HOLD, then en=0 in IDLE accepts nothing
        add(1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 8'h08, 1'b0, 1'b1, 3'd3);
        add(1'b0, 1'b1, 1'b0, 3'd0, RT, 8'h08, 1'b0, 1'b1, 3'd3);
        add(1'b0, 1'b1, 1'b0, 3'd0, RT, 8'h08, 1'b0, 1'b1, 3'd3);
        add(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3);
        add(1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd3);
        // abort in GAP
        add(1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 8'h40, 1'b0, 1'b1, 3'd6);
        for (int j = 0; j < 3; j++) add(1'b0, 1'b1, 1'b0, 3'd0, RT, 8'h40, 1'b0, 1'b1, 3'd6);
        add(1'b0, 1'b1, 1'b0, 3'd0, RT, 8'h00, 1'b1, 1'b1, 3'd6);
        add(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd6);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd6);
        // re-accept a=7 in the 2nd HOLD cycle
        add(1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 8'h04, 1'b0, 1'b1, 3'd2);
        add(1'b0, 1'b1, 1'b0, 3'd0, RT, 8'h04, 1'b0, 1'b1, 3'd2);
        if (RT) begin
            add(1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 8'h80, 1'b0, 1'b1, 3'd7);
            for (int j = 0; j < 3; j++) add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h80, 1'b0, 1'b1, 3'd7);
            add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd7);
            add(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7);
            add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd7);
        end else begin
            add(1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 8'h04, 1'b0, 1'b1, 3'd2);
            add(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h04, 1'b0, 1'b1, 3'd2);
            add(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd2);
            add(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2);
            add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd2);
        end
        // GAP=0 instance: next code follows the done cycle directly
        add(1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 8'h02, 1'b0, 1'b1, 3'd1);
        for (int j = 0; j < 3; j++) add(1'b1, 1'b1, ~RT, 3'd6, RT, 8'h02, 1'b0, 1'b1, 3'd1);
        add(1'b1, 1'b1, ~RT, 3'd6, RT, 8'h00, 1'b1, 1'b0, 3'd1);
        add(1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 8'h40, 1'b0, 1'b1, 3'd6);
        add(1'b1, 1'b1, 1'b0, 3'd0, RT, 8'h40, 1'b0, 1'b1, 3'd6);

        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; a = 3'd0;
        g_en = 1'b1; g_valid = 1'b0; g_a = 3'd0;
        #3;
        cmp("rst_y", y, 8'h00);
        cmp("rst_busy", busy, 8'd0);
        cmp("rst_done", done, 8'd0);
        cmp("rst_last_code", last_code, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cmp("rel_in_ready", in_ready, 8'd1);

        for (int k = 0; k < vecs.size(); k++) step(vecs[k]);

        // reset asserted mid-strobe clears at once; no done afterwards
        step(mk(1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 8'h10, 1'b0, 1'b1, 3'd4));
        step(mk(1'b0, 1'b1, 1'b0, 3'd0, RT, 8'h10, 1'b0, 1'b1, 3'd4));
        #2;
        rst_n = 1'b0;
        #1;
        cmp("mid_rst_y", y, 8'h00);
        cmp("mid_rst_busy", busy, 8'd0);
        cmp("mid_rst_done", done, 8'd0);
        cmp("mid_rst_last_code", last_code, 8'd0);
        cmp("mid_rst_g_y", g_y, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++)
            step(mk(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
